mem_req_arbiter: RTL and testbench

//  Shares the single main-memory model between three cache requesters: ICache refill read,

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_slot.sv | 32 +++
 rtl/mem_req_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the three-source main-memory request arbiter.
package mem_arb_pkg;

   // Arbiter FSM: idle/arbitrate, write issue, read issue, wait for read data
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      WAIT = 2'd3
   } arb_state_t;

   // Owner of the outstanding read; decides where the response is routed
   typedef enum logic {
      OWN_IC = 1'b0,
      OWN_DC = 1'b1
   } arb_owner_t;

endpackage

// File: rtl/mem_arb_slot.sv
// Single-entry request holding register. A set pulse captures the payload
// when empty; a set while full is dropped and flagged on ovf for one cycle.
module mem_arb_slot #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         set,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic         full,
   output logic [W-1:0] q,
   output logic         ovf
);

   // A request arriving while the slot is occupied is a protocol violation
   assign ovf = set & full;

   // Occupancy and payload; clear wins because the owner is done with it
   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 1'b0;
         q    <= '0;
      end else if (clr) begin
         full <= 1'b0;
      end else if (set && !full) begin
         full <= 1'b1;
         q    <= d;
      end
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares main memory between ICache refill, DCache refill and DCache
// writeback. One transaction in flight at a time; DC write > DC read > IC,
// except an IC read that has been passed over MAX_WAIT times wins outright.
module mem_req_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int BLOCK_DW = 256,
   parameter int MAX_WAIT = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                ic_rd_valid_i,
   input  logic [ADDR_W-1:0]   ic_rd_addr_i,
   output logic                ic_busy_o,
   output logic                ic_resp_valid_o,
   output logic [BLOCK_DW-1:0] ic_resp_data_o,
   input  logic                dc_rd_valid_i,
   input  logic [ADDR_W-1:0]   dc_rd_addr_i,
   input  logic                dc_wr_valid_i,
   input  logic [ADDR_W-1:0]   dc_wr_addr_i,
   input  logic [BLOCK_DW-1:0] dc_wr_data_i,
   output logic                dc_rd_busy_o,
   output logic                dc_wr_busy_o,
   output logic                dc_resp_valid_o,
   output logic [ADDR_W-1:0]   dc_resp_addr_o,
   output logic [BLOCK_DW-1:0] dc_resp_data_o,
   output logic                mem_rd_valid_o,
   output logic [ADDR_W-1:0]   mem_rd_addr_o,
   output logic                mem_wr_valid_o,
   output logic [ADDR_W-1:0]   mem_wr_addr_o,
   output logic [BLOCK_DW-1:0] mem_wr_data_o,
   input  logic                mem_rd_valid_i,
   input  logic [BLOCK_DW-1:0] mem_rd_data_i,
   output logic                err_o
);

   localparam logic [7:0] MAX_AGE = 8'(MAX_WAIT);

   arb_state_t state;
   arb_owner_t owner;
   logic [7:0] age;

   logic                       ic_full, dcr_full, dcw_full;
   logic                       ic_ovf, dcr_ovf, dcw_ovf;
   logic                       ic_clr, dcr_clr, dcw_clr;
   logic [ADDR_W-1:0]          ic_addr, dcr_addr;
   logic [ADDR_W+BLOCK_DW-1:0] dcw_q;
   logic                       rd_done;
   logic                       grant_ic, grant_dcr, grant_dcw;

   // Read slots free when their data comes back; write slot frees on issue
   assign rd_done = (state == WAIT) && mem_rd_valid_i;
   assign ic_clr  = rd_done && (owner == OWN_IC);
   assign dcr_clr = rd_done && (owner == OWN_DC);
   assign dcw_clr = (state == WR);

   mem_arb_slot #(.W(ADDR_W)) u_ic_slot (
      .clk(clk_i), .rst(rst_i), .set(ic_rd_valid_i), .clr(ic_clr),
      .d(ic_rd_addr_i), .full(ic_full), .q(ic_addr), .ovf(ic_ovf)
   );

   mem_arb_slot #(.W(ADDR_W)) u_dcr_slot (
      .clk(clk_i), .rst(rst_i), .set(dc_rd_valid_i), .clr(dcr_clr),
      .d(dc_rd_addr_i), .full(dcr_full), .q(dcr_addr), .ovf(dcr_ovf)
   );

   mem_arb_slot #(.W(ADDR_W + BLOCK_DW)) u_dcw_slot (
      .clk(clk_i), .rst(rst_i), .set(dc_wr_valid_i), .clr(dcw_clr),
      .d({dc_wr_addr_i, dc_wr_data_i}), .full(dcw_full), .q(dcw_q), .ovf(dcw_ovf)
   );

   assign ic_busy_o    = ic_full;
   assign dc_rd_busy_o = dcr_full;
   assign dc_wr_busy_o = dcw_full;

   // Winner selection from registered slots only; starved IC overrides
   always_comb begin
      grant_ic  = 1'b0;
      grant_dcr = 1'b0;
      grant_dcw = 1'b0;
      if (state == IDLE) begin
         if (ic_full && (age == MAX_AGE)) grant_ic  = 1'b1;
         else if (dcw_full)               grant_dcw = 1'b1;
         else if (dcr_full)               grant_dcr = 1'b1;
         else if (ic_full)                grant_ic  = 1'b1;
      end
   end

   // FSM and registered memory-side issue; memory outputs are 0 except on issue
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= IDLE;
         owner          <= OWN_IC;
         mem_rd_valid_o <= 1'b0;
         mem_rd_addr_o  <= '0;
         mem_wr_valid_o <= 1'b0;
         mem_wr_addr_o  <= '0;
         mem_wr_data_o  <= '0;
      end else begin
         mem_rd_valid_o <= 1'b0;
         mem_rd_addr_o  <= '0;
         mem_wr_valid_o <= 1'b0;
         mem_wr_addr_o  <= '0;
         mem_wr_data_o  <= '0;
         case (state)
            IDLE: begin
               if (grant_dcw) begin
                  state          <= WR;
                  mem_wr_valid_o <= 1'b1;
                  mem_wr_addr_o  <= dcw_q[ADDR_W+BLOCK_DW-1:BLOCK_DW];
                  mem_wr_data_o  <= dcw_q[BLOCK_DW-1:0];
               end else if (grant_dcr) begin
                  state          <= RD;
                  owner          <= OWN_DC;
                  mem_rd_valid_o <= 1'b1;
                  mem_rd_addr_o  <= dcr_addr;
               end else if (grant_ic) begin
                  state          <= RD;
                  owner          <= OWN_IC;
                  mem_rd_valid_o <= 1'b1;
                  mem_rd_addr_o  <= ic_addr;
               end
            end
            WR:      state <= IDLE;
            RD:      state <= WAIT;
            WAIT:    if (mem_rd_valid_i) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // IC aging: count arbitrations the IC loses while pending, saturating
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         age <= '0;
      end else if (grant_ic) begin
         age <= '0;
      end else if (ic_full && (grant_dcw || grant_dcr) && (age < MAX_AGE)) begin
         age <= age + 8'd1;
      end
   end

   // Route read data to its owner with a one-cycle response pulse
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ic_resp_valid_o <= 1'b0;
         ic_resp_data_o  <= '0;
         dc_resp_valid_o <= 1'b0;
         dc_resp_addr_o  <= '0;
         dc_resp_data_o  <= '0;
      end else begin
         ic_resp_valid_o <= 1'b0;
         dc_resp_valid_o <= 1'b0;
         if (ic_clr) begin
            ic_resp_valid_o <= 1'b1;
            ic_resp_data_o  <= mem_rd_data_i;
         end
         if (dcr_clr) begin
            dc_resp_valid_o <= 1'b1;
            dc_resp_addr_o  <= dcr_addr;
            dc_resp_data_o  <= mem_rd_data_i;
         end
      end
   end

   // Sticky protocol error: dropped request pulse or unsolicited read data
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_o <= 1'b0;
      end else if (ic_ovf || dcr_ovf || dcw_ovf || (mem_rd_valid_i && (state != WAIT))) begin
         err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed scenarios followed by a randomized run against a transaction-level
// model of the arbiter (pending requests, issue order, aging, responses).
module tb_mem_req_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 256;
   localparam int MW  = 2;
   localparam int BIG = 32'h7fff_0000;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          ic_rd_valid_i, dc_rd_valid_i, dc_wr_valid_i, mem_rd_valid_i;
   logic [AW-1:0] ic_rd_addr_i, dc_rd_addr_i, dc_wr_addr_i;
   logic [DW-1:0] dc_wr_data_i, mem_rd_data_i;
   logic          ic_busy_o, ic_resp_valid_o, dc_rd_busy_o, dc_wr_busy_o, dc_resp_valid_o;
   logic          mem_rd_valid_o, mem_wr_valid_o, err_o;
   logic [DW-1:0] ic_resp_data_o, dc_resp_data_o, mem_wr_data_o;
   logic [AW-1:0] dc_resp_addr_o, mem_rd_addr_o, mem_wr_addr_o;

   int cyc = 0;
   int nchk = 0;
   int nfail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_req_arbiter #(.ADDR_W(AW), .BLOCK_DW(DW), .MAX_WAIT(MW)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .ic_rd_valid_i(ic_rd_valid_i), .ic_rd_addr_i(ic_rd_addr_i), .ic_busy_o(ic_busy_o),
      .ic_resp_valid_o(ic_resp_valid_o), .ic_resp_data_o(ic_resp_data_o),
      .dc_rd_valid_i(dc_rd_valid_i), .dc_rd_addr_i(dc_rd_addr_i),
      .dc_wr_valid_i(dc_wr_valid_i), .dc_wr_addr_i(dc_wr_addr_i), .dc_wr_data_i(dc_wr_data_i),
      .dc_rd_busy_o(dc_rd_busy_o), .dc_wr_busy_o(dc_wr_busy_o),
      .dc_resp_valid_o(dc_resp_valid_o), .dc_resp_addr_o(dc_resp_addr_o),
      .dc_resp_data_o(dc_resp_data_o),
      .mem_rd_valid_o(mem_rd_valid_o), .mem_rd_addr_o(mem_rd_addr_o),
      .mem_wr_valid_o(mem_wr_valid_o), .mem_wr_addr_o(mem_wr_addr_o),
      .mem_wr_data_o(mem_wr_data_o),
      .mem_rd_valid_i(mem_rd_valid_i), .mem_rd_data_i(mem_rd_data_i),
      .err_o(err_o)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      ic_rd_valid_i  = 1'b0; ic_rd_addr_i = '0;
      dc_rd_valid_i  = 1'b0; dc_rd_addr_i = '0;
      dc_wr_valid_i  = 1'b0; dc_wr_addr_i = '0; dc_wr_data_i = '0;
      mem_rd_valid_i = 1'b0; mem_rd_data_i = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
   endtask

   function automatic logic [DW-1:0] rnd_blk();
      logic [DW-1:0] r;
      for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // model state for the randomized phase
   bit            pv[3];      // 0 = IC read, 1 = DC read, 2 = DC write
   logic [AW-1:0] pa[3];
   int            st[3];      // first cycle the slot is visible to arbitration
   logic [DW-1:0] pwd, rdat;
   int            age, free_at, own, resp_at, c, win;
   bit            ic_el, rd_el, wr_el, exp_issue, due;

   logic [DW-1:0] paa, p55, pb, pc;

   initial begin
      paa = {32{8'hAA}};
      p55 = {32{8'h55}};
      pb  = {32{8'h3C}};
      pc  = {32{8'hC3}};
      idle_inputs();
      rst_i = 1'b1;

      // ---- 1: reset state, then a single IC read with 5-cycle memory latency
      step(); step();
      chk("rst_ic_busy", ic_busy_o, 0);
      chk("rst_dc_busy", {dc_rd_busy_o, dc_wr_busy_o}, 0);
      chk("rst_mem_rd", mem_rd_valid_o, 0);
      chk("rst_mem_wr", mem_wr_valid_o, 0);
      chk("rst_resp", {ic_resp_valid_o, dc_resp_valid_o}, 0);
      chk("rst_err", err_o, 0);
      chk("rst_ic_data", ic_resp_data_o, 0);
      rst_i = 1'b0;
      ic_rd_valid_i = 1'b1; ic_rd_addr_i = 32'h100;
      step(); ic_rd_valid_i = 1'b0;
      chk("t1_busy_c1", ic_busy_o, 1);
      chk("t1_noissue_c1", mem_rd_valid_o, 0);
      step();
      chk("t1_issue_c2", mem_rd_valid_o, 1);
      chk("t1_issue_addr", mem_rd_addr_o, 32'h100);
      step();
      chk("t1_issue_once", mem_rd_valid_o, 0);
      repeat (4) step();
      chk("t1_no_early_resp", ic_resp_valid_o, 0);
      mem_rd_valid_i = 1'b1; mem_rd_data_i = paa;
      step(); mem_rd_valid_i = 1'b0;
      chk("t1_resp", ic_resp_valid_o, 1);
      chk("t1_resp_data", ic_resp_data_o, paa);
      chk("t1_no_dc_resp", dc_resp_valid_o, 0);
      step();
      chk("t1_resp_pulse", ic_resp_valid_o, 0);
      chk("t1_slot_free", ic_busy_o, 0);

      // ---- 2: same-cycle DC write and read to one block: write issues first
      do_reset();
      dc_wr_valid_i = 1'b1; dc_wr_addr_i = 32'h200; dc_wr_data_i = p55;
      dc_rd_valid_i = 1'b1; dc_rd_addr_i = 32'h200;
      step(); dc_wr_valid_i = 1'b0; dc_rd_valid_i = 1'b0;
      chk("t2_busy", {dc_rd_busy_o, dc_wr_busy_o}, 2'b11);
      step();
      chk("t2_wr_first", mem_wr_valid_o, 1);
      chk("t2_wr_addr", mem_wr_addr_o, 32'h200);
      chk("t2_wr_data", mem_wr_data_o, p55);
      chk("t2_rd_not_yet", mem_rd_valid_o, 0);
      step();
      chk("t2_wr_once", mem_wr_valid_o, 0);
      chk("t2_wr_slot_free", dc_wr_busy_o, 0);
      step();
      chk("t2_rd_issue", mem_rd_valid_o, 1);
      chk("t2_rd_addr", mem_rd_addr_o, 32'h200);
      step();
      mem_rd_valid_i = 1'b1; mem_rd_data_i = p55;
      step(); mem_rd_valid_i = 1'b0;
      chk("t2_resp", dc_resp_valid_o, 1);
      chk("t2_resp_addr", dc_resp_addr_o, 32'h200);
      chk("t2_resp_data", dc_resp_data_o, p55);
      chk("t2_no_ic_resp", ic_resp_valid_o, 0);

      // ---- 3: IC aging with MAX_WAIT=2
      do_reset();
      ic_rd_valid_i = 1'b1; ic_rd_addr_i = 32'h300;
      dc_wr_valid_i = 1'b1; dc_wr_addr_i = 32'h400; dc_wr_data_i = pb;
      step(); ic_rd_valid_i = 1'b0; dc_wr_valid_i = 1'b0;
      step();
      chk("t3_arb1_wr", mem_wr_valid_o, 1);
      chk("t3_arb1_addr", mem_wr_addr_o, 32'h400);
      dc_rd_valid_i = 1'b1; dc_rd_addr_i = 32'h500;
      step(); dc_rd_valid_i = 1'b0;
      dc_wr_valid_i = 1'b1; dc_wr_addr_i = 32'h600; dc_wr_data_i = pc;
      step(); dc_wr_valid_i = 1'b0;
      chk("t3_arb2_dcrd", mem_rd_valid_o, 1);
      chk("t3_arb2_addr", mem_rd_addr_o, 32'h500);
      step();
      mem_rd_valid_i = 1'b1; mem_rd_data_i = pb;
      step(); mem_rd_valid_i = 1'b0;
      chk("t3_dc_resp", dc_resp_valid_o, 1);
      step();
      chk("t3_arb3_ic", mem_rd_valid_o, 1);
      chk("t3_arb3_addr", mem_rd_addr_o, 32'h300);
      chk("t3_arb3_not_wr", mem_wr_valid_o, 0);
      step();
      mem_rd_valid_i = 1'b1; mem_rd_data_i = pc;
      step(); mem_rd_valid_i = 1'b0;
      chk("t3_ic_resp", ic_resp_valid_o, 1);
      chk("t3_ic_data", ic_resp_data_o, pc);
      ic_rd_valid_i = 1'b1; ic_rd_addr_i = 32'h700;
      dc_rd_valid_i = 1'b1; dc_rd_addr_i = 32'h710;
      step(); ic_rd_valid_i = 1'b0; dc_rd_valid_i = 1'b0;
      chk("t3_wr_after", mem_wr_valid_o, 1);
      chk("t3_wr_after_addr", mem_wr_addr_o, 32'h600);
      step(); step();
      chk("t3_age_cleared", mem_rd_addr_o, 32'h710);

      // ---- 4: protocol errors
      do_reset();
      chk("t4_err_clear", err_o, 0);
      mem_rd_valid_i = 1'b1; mem_rd_data_i = paa;
      step(); mem_rd_valid_i = 1'b0;
      chk("t4_err_stray_rd", err_o, 1);
      chk("t4_no_resp", ic_resp_valid_o | dc_resp_valid_o, 0);
      step();
      chk("t4_err_sticky", err_o, 1);
      do_reset();
      chk("t4_err_reset", err_o, 0);
      ic_rd_valid_i = 1'b1; ic_rd_addr_i = 32'h800;
      step();
      chk("t4_busy_pre", ic_busy_o, 1);
      ic_rd_addr_i = 32'h900;
      step(); ic_rd_valid_i = 1'b0;
      chk("t4_err_ovf", err_o, 1);
      chk("t4_kept_first", mem_rd_addr_o, 32'h800);
      step(); step();
      chk("t4_err_held", err_o, 1);

      // ---- 5: reset during WAIT, late data ignored
      do_reset();
      ic_rd_valid_i = 1'b1; ic_rd_addr_i = 32'hA00;
      step(); ic_rd_valid_i = 1'b0;
      step();
      chk("t5_issue", mem_rd_valid_o, 1);
      step();
      rst_i = 1'b1;
      step(); rst_i = 1'b0;
      chk("t5_rst_busy", ic_busy_o, 0);
      chk("t5_rst_err", err_o, 0);
      mem_rd_valid_i = 1'b1; mem_rd_data_i = paa;
      step(); mem_rd_valid_i = 1'b0;
      chk("t5_no_resp", ic_resp_valid_o, 0);
      chk("t5_err_late", err_o, 1);
      chk("t5_slots_empty", {ic_busy_o, dc_rd_busy_o, dc_wr_busy_o}, 0);
      dc_rd_valid_i = 1'b1; dc_rd_addr_i = 32'hB00;
      step(); dc_rd_valid_i = 1'b0;
      chk("t5_no_resp2", ic_resp_valid_o, 0);
      step();
      chk("t5_idle_issue", mem_rd_valid_o, 1);
      chk("t5_idle_addr", mem_rd_addr_o, 32'hB00);

      // ---- randomized traffic against the transaction-level model
      do_reset();
      for (int i = 0; i < 3; i++) begin pv[i] = 0; pa[i] = '0; st[i] = 0; end
      pwd = '0; rdat = '0;
      age = 0; own = -1; resp_at = BIG; free_at = cyc;
      for (int it = 0; it < 3000; it++) begin
         step();
         c = cyc;
         ic_rd_valid_i = 1'b0; dc_rd_valid_i = 1'b0; dc_wr_valid_i = 1'b0;
         mem_rd_valid_i = 1'b0;

         // expected memory issue this cycle
         ic_el = pv[0] && (st[0] <= c - 1);
         rd_el = pv[1] && (st[1] <= c - 1);
         wr_el = pv[2] && (st[2] <= c - 1);
         exp_issue = (free_at <= c - 1) && (ic_el || rd_el || wr_el);
         if (ic_el && age == MW) win = 0;
         else if (wr_el)         win = 2;
         else if (rd_el)         win = 1;
         else                    win = 0;
         chk("r_wr_issue", mem_wr_valid_o, exp_issue && win == 2);
         chk("r_rd_issue", mem_rd_valid_o, exp_issue && win != 2);
         if (exp_issue) begin
            if (win == 2) begin
               chk("r_wr_addr", mem_wr_addr_o, pa[2]);
               chk("r_wr_data", mem_wr_data_o, pwd);
               pv[2] = 0;
               free_at = c + 1;
            end else begin
               chk("r_rd_addr", mem_rd_addr_o, pa[win]);
               own = win;
               resp_at = c + int'($urandom_range(1, 4));
               free_at = BIG;
            end
            if (win == 0) age = 0;
            else if (ic_el && age < MW) age++;
         end

         // expected response routing
         due = (own >= 0) && (c == resp_at + 1);
         chk("r_ic_resp", ic_resp_valid_o, due && own == 0);
         chk("r_dc_resp", dc_resp_valid_o, due && own == 1);
         if (due) begin
            if (own == 0) begin
               chk("r_ic_data", ic_resp_data_o, rdat);
            end else begin
               chk("r_dc_data", dc_resp_data_o, rdat);
               chk("r_dc_addr", dc_resp_addr_o, pa[1]);
            end
            pv[own] = 0;
            own = -1;
            resp_at = BIG;
            free_at = c;
         end
         chk("r_err", err_o, 0);

         // drive memory data and new requests
         if (own >= 0 && c == resp_at) begin
            rdat = rnd_blk();
            mem_rd_valid_i = 1'b1; mem_rd_data_i = rdat;
         end
         if (!ic_busy_o && !pv[0] && $urandom_range(0, 3) == 0) begin
            pa[0] = $urandom; pv[0] = 1; st[0] = c + 1;
            ic_rd_valid_i = 1'b1; ic_rd_addr_i = pa[0];
         end
         if (!dc_rd_busy_o && !pv[1] && $urandom_range(0, 3) == 0) begin
            pa[1] = $urandom; pv[1] = 1; st[1] = c + 1;
            dc_rd_valid_i = 1'b1; dc_rd_addr_i = pa[1];
         end
         if (!dc_wr_busy_o && !pv[2] && $urandom_range(0, 3) == 0) begin
            pa[2] = $urandom; pwd = rnd_blk(); pv[2] = 1; st[2] = c + 1;
            dc_wr_valid_i = 1'b1; dc_wr_addr_i = pa[2]; dc_wr_data_i = pwd;
         end
      end
      idle_inputs();
      step();

      $display("[TB] %0d tests run, %0d failed", nchk, nfail);
      $finish;
   end

endmodule
